led_bank_arbiter: RTL and testbench
===================================

Name: led_bank_arbiter

Overview:
- Shares one board LED bank (LEDR) between NUM_REQ custom-Verilog requesters, each of which drives its own LED value.
- Uses round-robin grants with an optional hold-time limit.
- Sequenced by the standard LegUp start/finish handshake. The operator ends a run by pressing and releasing KEY[3].
- Sits between the generated circuit's custom-Verilog instances and the LEDR pins.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- LED_W, 6, LED bank width in bits.
- MAX_HOLD, 1000, maximum cycles a grant may be held; 0 disables the timeout.
- CNT_W, 16, hold-counter width; MAX_HOLD must be less than 2^CNT_W.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  LegUp start pulse; accepted only in IDLE
- KEY  in  4  board keys, active-low, asynchronous; only KEY[3] is used
- req  in  NUM_REQ  per-requester request, level
- rel  in  NUM_REQ  per-requester release, 1-cycle pulse
- led_in  in  NUM_REQ*LED_W  flattened LED values; requester i occupies bits [i*LED_W +: LED_W]
- grant  out  NUM_REQ  one-hot grant, registered
- LEDR  out  LED_W  shared LED bank, registered
- timeout  out  1  1-cycle pulse when a grant is revoked by MAX_HOLD
- finish  out  1  1-cycle LegUp finish pulse

Behaviour:
- Reset (asynchronous, active-high) values: state=IDLE, grant=0, LEDR=0, timeout=0, finish=0, last=NUM_REQ-1, hold counter=0, stop_pending=0, key synchronizer flops=1.
- KEY[3] handling:
  - Passed through a 2-flop synchronizer; k = synchronized level.
  - seen_low is set when k=0 while in ARB or GRANT.
  - stop_pending is set on k=1 with seen_low=1, i.e. on release after a press.
  - Both flags clear in IDLE.
- IDLE:
  - grant=0 and LEDR=0.
  - start=1 -> ARB on the next edge.
  - start in any other state is ignored.
- ARB:
  - If stop_pending=1 -> DONE, even when requests are pending.
  - Otherwise, if any req bit is set, choose the first set bit searching last+1, last+2, ... modulo NUM_REQ.
  - Then set grant one-hot, set last to the chosen index, clear the hold counter, and go to GRANT. All of these happen on the same edge.
  - If no req bit is set, stay in ARB.
- GRANT (g = granted index):
  - LEDR <= led_in[g] every cycle. LEDR lags led_in by one cycle.
  - The hold counter increments every cycle.
  - The grant ends on the first of: rel[g]=1, req[g]=0, or (MAX_HOLD!=0 and counter==MAX_HOLD-1).
  - On end: grant<=0 and go to ARB. LEDR keeps its last value.
  - On the timeout cause only (no rel, req still high), timeout=1 for exactly one cycle, coincident with grant falling.
  - rel or req edges from non-granted requesters are ignored.
  - stop_pending does not preempt a grant; it takes effect in the next ARB.
- DONE:
  - finish=1 for exactly one cycle, LEDR<=0, then IDLE.
- Re-grant and timing rules:
  - The minimum gap between grants is 1 cycle (the ARB cycle); grant is never high for two requesters at once.
  - A requester that releases and still has req high may be re-granted only after every other asserted requester has been served.
  - Latency from start to the first grant is 2 edges: IDLE->ARB, then ARB->GRANT.
- Reset mid-operation: all outputs return to reset values immediately; a pending stop is discarded.

Test Plan:
- Reset, start; req=2'b01, led_in[0]=6'h15 -> grant=01 two cycles after start; LEDR=6'h15 one cycle later; rel[0] pulse -> grant=00 on the next edge.
- req=2'b11 held, rel pulsed on each grant, last=1 at start -> grant sequence 01,10,01,10 with one idle ARB cycle between each.
- MAX_HOLD=4, req[1]=1, no rel -> grant[1] high for exactly 4 cycles; timeout pulses once as grant falls; re-grant follows ARB.
- KEY[3] low 5 cycles then high while req0 is granted -> grant continues until rel[0]; next ARB -> DONE; finish=1 for one cycle; LEDR=0; state IDLE.
- KEY[3] glitch during IDLE, then start -> no stop (flags cleared in IDLE); normal arbitration proceeds.
- Assert reset during GRANT with LEDR=6'h3F -> grant=0, LEDR=0, finish=0 asynchronously; a new start works normally.

Source files
------------

// File: rtl/led_bank_arbiter.sv
// led_bank_arbiter: shares one LED bank between NUM_REQ requesters using
// round-robin grants with an optional hold-time limit. A run is framed by the
// LegUp start/finish handshake and ended by a press-and-release of KEY[3].
module led_bank_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int LED_W    = 6,
  parameter int MAX_HOLD = 1000,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [3:0]                 KEY,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         rel,
  input  logic [NUM_REQ*LED_W-1:0]   led_in,
  output logic [NUM_REQ-1:0]         grant,
  output logic [LED_W-1:0]           LEDR,
  output logic                       timeout,
  output logic                       finish
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0]   LAST_RST  = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1'b1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1'b1);
  // MAX_HOLD of zero disables the limit; guard the MAX_HOLD-1 underflow.
  localparam bit                 HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0]   HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    GRANT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [LED_W-1:0]     ledr_q, ledr_d;
  logic                 timeout_q, timeout_d;
  logic                 finish_q, finish_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 seen_low_q, seen_low_d;
  logic                 stop_q, stop_d;
  logic                 key_meta_q, key_sync_q;

  logic                 found_s;
  logic [IDX_W-1:0]     pick_s;
  logic [IDX_W:0]       cand_s;
  logic                 take_s;
  logic [LED_W-1:0]     led_sel_s;
  logic                 rel_g_s;
  logic                 req_g_s;
  logic                 hold_hit_s;
  logic                 unused_key_s;

  // Only KEY[3] stops a run; the other keys are deliberately ignored.
  assign unused_key_s = ^KEY[2:0];

  // LED value of the currently granted requester (last holds the grant index).
  assign led_sel_s = led_in[int'(last_q)*LED_W +: LED_W];

  // Two-flop synchronizer for the asynchronous, active-low KEY[3].
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_meta_q <= 1'b1;
      key_sync_q <= 1'b1;
    end else begin
      key_meta_q <= KEY[3];
      key_sync_q <= key_meta_q;
    end
  end

  // Stop detection: remember a press seen while running, flag its release.
  always_comb begin
    seen_low_d = seen_low_q;
    stop_d     = stop_q;
    if (state_q == IDLE) begin
      seen_low_d = 1'b0;
      stop_d     = 1'b0;
    end else begin
      if (((state_q == ARB) || (state_q == GRANT)) && !key_sync_q) begin
        seen_low_d = 1'b1;
      end else begin
        seen_low_d = seen_low_q;
      end
      if (key_sync_q && seen_low_q) begin
        stop_d = 1'b1;
      end else begin
        stop_d = stop_q;
      end
    end
  end

  // Round-robin search starting just after the last granted index.
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    cand_s  = '0;
    take_s  = 1'b0;
    for (int o = 1; o <= NUM_REQ; o++) begin
      cand_s = {1'b0, last_q} + (IDX_W+1)'(o);
      cand_s = (cand_s >= (IDX_W+1)'(NUM_REQ)) ? (cand_s - (IDX_W+1)'(NUM_REQ)) : cand_s;
      take_s  = !found_s && req[cand_s[IDX_W-1:0]];
      pick_s  = take_s ? cand_s[IDX_W-1:0] : pick_s;
      found_s = found_s | take_s;
    end
  end

  // Next-state and registered-output logic for the arbitration FSM.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ledr_d     = ledr_q;
    timeout_d  = 1'b0;
    finish_d   = 1'b0;
    last_d     = last_q;
    cnt_d      = cnt_q;
    rel_g_s    = rel[last_q];
    req_g_s    = req[last_q];
    hold_hit_s = HOLD_EN && (cnt_q == HOLD_LAST);
    case (state_q)
      IDLE: begin
        grant_d = '0;
        ledr_d  = '0;
        cnt_d   = '0;
        if (start) begin
          state_d = ARB;
        end else begin
          state_d = IDLE;
        end
      end
      ARB: begin
        // A pending stop wins over any outstanding request.
        if (stop_q) begin
          state_d  = DONE;
          finish_d = 1'b1;
          ledr_d   = '0;
          grant_d  = '0;
        end else if (found_s) begin
          state_d = GRANT;
          grant_d = ONE_HOT0 << pick_s;
          last_d  = pick_s;
          cnt_d   = '0;
        end else begin
          state_d = ARB;
        end
      end
      GRANT: begin
        ledr_d = led_sel_s;
        cnt_d  = cnt_q + CNT_ONE;
        if (rel_g_s || !req_g_s || hold_hit_s) begin
          grant_d   = '0;
          state_d   = ARB;
          // Only a pure hold-limit revocation is reported as a timeout.
          timeout_d = hold_hit_s && !rel_g_s && req_g_s;
        end else begin
          state_d = GRANT;
        end
      end
      DONE: begin
        grant_d = '0;
        ledr_d  = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        ledr_d  = '0;
      end
    endcase
  end

  // State and output registers; reset discards any pending stop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      ledr_q     <= '0;
      timeout_q  <= 1'b0;
      finish_q   <= 1'b0;
      last_q     <= LAST_RST;
      cnt_q      <= '0;
      seen_low_q <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ledr_q     <= ledr_d;
      timeout_q  <= timeout_d;
      finish_q   <= finish_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      seen_low_q <= seen_low_d;
      stop_q     <= stop_d;
    end
  end

  assign grant   = grant_q;
  assign LEDR    = ledr_q;
  assign timeout = timeout_q;
  assign finish  = finish_q;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Directed, table-driven bench for led_bank_arbiter plus hand-written
// sequences for hold timeout, KEY[3] stop, IDLE key glitch and async reset.
module tb_led_bank_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  KEY;
  logic [1:0]  req;
  logic [1:0]  rel;
  logic [11:0] led_in;
  logic [1:0]  grant,   grant_t;
  logic [5:0]  LEDR,    LEDR_t;
  logic        timeout, timeout_t;
  logic        finish,  finish_t;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  led_bank_arbiter #(.NUM_REQ(2), .LED_W(6), .MAX_HOLD(1000), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .KEY(KEY), .req(req), .rel(rel),
    .led_in(led_in), .grant(grant), .LEDR(LEDR), .timeout(timeout), .finish(finish)
  );

  led_bank_arbiter #(.NUM_REQ(2), .LED_W(6), .MAX_HOLD(4), .CNT_W(16)) dut_to (
    .clk(clk), .reset(reset), .start(start), .KEY(KEY), .req(req), .rel(rel),
    .led_in(led_in), .grant(grant_t), .LEDR(LEDR_t), .timeout(timeout_t), .finish(finish_t)
  );

  typedef struct {
    logic       rst;
    logic       st;
    logic [1:0] rq;
    logic [1:0] rl;
    logic [5:0] led0;
    logic [5:0] led1;
    logic [1:0] eg;
    logic [5:0] el;
    logic       et;
    logic       ef;
  } vec_t;

  vec_t tbl[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [1:0] g, input logic [5:0] l,
                       input logic t, input logic f, input logic [1:0] eg,
                       input logic [5:0] el, input logic et, input logic ef);
    n_vec++;
    if ({g, l, t, f} !== {eg, el, et, ef}) begin
      n_err++;
      $display("FAIL %s: got grant=%b LEDR=%h timeout=%b finish=%b, want grant=%b LEDR=%h timeout=%b finish=%b",
               nm, g, l, t, f, eg, el, et, ef);
    end
  endtask

  task automatic chk1(input string nm, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, want %b", nm, got, exp);
    end
  endtask

  initial begin
    logic got_fin;
    logic saw_grant;

    // rst st  req    rel    led0   led1   grant  LEDR   to    fin
    tbl.push_back('{1'b0, 1'b1, 2'b01, 2'b00, 6'h15, 6'h2A, 2'b00, 6'h00, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 2'b01, 2'b00, 6'h15, 6'h2A, 2'b01, 6'h00, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 2'b01, 2'b00, 6'h15, 6'h2A, 2'b01, 6'h15, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 2'b01, 2'b01, 6'h15, 6'h2A, 2'b00, 6'h15, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 2'b00, 2'b00, 6'h15, 6'h2A, 2'b00, 6'h15, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 2'b00, 2'b00, 6'h15, 6'h2A, 2'b00, 6'h00, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 2'b11, 2'b00, 6'h15, 6'h2A, 2'b00, 6'h00, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 2'b11, 2'b00, 6'h15, 6'h2A, 2'b01, 6'h00, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 2'b11, 2'b01, 6'h15, 6'h2A, 2'b00, 6'h15, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 2'b11, 2'b00, 6'h15, 6'h2A, 2'b10, 6'h15, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 2'b11, 2'b10, 6'h15, 6'h2A, 2'b00, 6'h2A, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 2'b11, 2'b00, 6'h15, 6'h2A, 2'b01, 6'h2A, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 2'b11, 2'b01, 6'h15, 6'h2A, 2'b00, 6'h15, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 2'b11, 2'b00, 6'h15, 6'h2A, 2'b10, 6'h15, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 2'b11, 2'b10, 6'h15, 6'h2A, 2'b00, 6'h2A, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 2'b00, 2'b00, 6'h15, 6'h2A, 2'b00, 6'h2A, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 2'b10, 2'b00, 6'h15, 6'h0C, 2'b10, 6'h2A, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 2'b11, 2'b01, 6'h15, 6'h0C, 2'b10, 6'h0C, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 2'b01, 2'b00, 6'h15, 6'h0C, 2'b00, 6'h0C, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 2'b01, 2'b00, 6'h15, 6'h0C, 2'b01, 6'h0C, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 2'b00, 2'b00, 6'h15, 6'h0C, 2'b00, 6'h15, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 2'b00, 2'b00, 6'h15, 6'h0C, 2'b00, 6'h15, 1'b0, 1'b0});

    reset  = 1'b1;
    start  = 1'b0;
    KEY    = 4'hF;
    req    = 2'b00;
    rel    = 2'b00;
    led_in = 12'h000;
    step();
    step();
    check("reset_state", grant, LEDR, timeout, finish, 2'b00, 6'h00, 1'b0, 1'b0);

    // Table: single grant, round-robin alternation, req-drop end, ignored rel.
    for (int i = 0; i < tbl.size(); i++) begin
      reset  = tbl[i].rst;
      start  = tbl[i].st;
      req    = tbl[i].rq;
      rel    = tbl[i].rl;
      led_in = {tbl[i].led1, tbl[i].led0};
      step();
      check($sformatf("vec%0d", i), grant, LEDR, timeout, finish,
            tbl[i].eg, tbl[i].el, tbl[i].et, tbl[i].ef);
    end

    // Hold limit of 4 on dut_to: grant[1] for exactly 4 cycles, then timeout.
    reset = 1'b1; start = 1'b0; req = 2'b00; rel = 2'b00;
    led_in = {6'h0C, 6'h15};
    step();
    reset = 1'b0; start = 1'b1; req = 2'b10;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("hold%0d", i), grant_t, LEDR_t, timeout_t, finish_t,
            2'b10, (i == 0) ? 6'h00 : 6'h0C, 1'b0, 1'b0);
    end
    step();
    check("timeout_revoke", grant_t, LEDR_t, timeout_t, finish_t, 2'b00, 6'h0C, 1'b1, 1'b0);
    step();
    check("timeout_regrant", grant_t, LEDR_t, timeout_t, finish_t, 2'b10, 6'h0C, 1'b0, 1'b0);
    req = 2'b00;
    step();

    // KEY[3] press/release during a grant: grant runs to rel, then DONE.
    reset = 1'b1;
    step();
    reset = 1'b0; start = 1'b1; req = 2'b01; led_in = {6'h2A, 6'h15};
    step();
    start = 1'b0;
    step();
    check("key_grant", grant, LEDR, timeout, finish, 2'b01, 6'h00, 1'b0, 1'b0);
    KEY = 4'h7;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("key_low%0d", i), grant, LEDR, timeout, finish, 2'b01, 6'h15, 1'b0, 1'b0);
    end
    KEY = 4'hF;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("key_high%0d", i), grant, LEDR, timeout, finish, 2'b01, 6'h15, 1'b0, 1'b0);
    end
    rel = 2'b01;
    step();
    rel = 2'b00;
    check("key_rel", grant, LEDR, timeout, finish, 2'b00, 6'h15, 1'b0, 1'b0);
    got_fin   = 1'b0;
    saw_grant = 1'b0;
    for (int w = 0; w < 4 && !got_fin; w++) begin
      step();
      if (finish === 1'b1) got_fin = 1'b1;
      if (grant !== 2'b00) saw_grant = 1'b1;
    end
    chk1("finish_seen", got_fin, 1'b1);
    chk1("no_regrant_after_stop", saw_grant, 1'b0);
    check("done_outs", grant, LEDR, timeout, finish, 2'b00, 6'h00, 1'b0, 1'b1);
    step();
    check("finish_one_cycle", grant, LEDR, timeout, finish, 2'b00, 6'h00, 1'b0, 1'b0);

    // Back in IDLE: requests ignored, KEY glitch must not arm a stop.
    KEY = 4'h7;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("idle_hold%0d", i), grant, LEDR, timeout, finish, 2'b00, 6'h00, 1'b0, 1'b0);
    end
    KEY = 4'hF;
    step(); step(); step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("glitch_grant", grant, LEDR, timeout, finish, 2'b01, 6'h00, 1'b0, 1'b0);
    step();
    check("glitch_led", grant, LEDR, timeout, finish, 2'b01, 6'h15, 1'b0, 1'b0);
    rel = 2'b01;
    step();
    rel = 2'b00;
    check("glitch_rel", grant, LEDR, timeout, finish, 2'b00, 6'h15, 1'b0, 1'b0);
    step();
    check("glitch_regrant", grant, LEDR, timeout, finish, 2'b01, 6'h15, 1'b0, 1'b0);
    req = 2'b00;
    step();
    check("glitch_end", grant, LEDR, timeout, finish, 2'b00, 6'h15, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a grant, then a clean restart.
    led_in = {6'h2A, 6'h3F};
    req = 2'b01;
    step();
    step();
    check("pre_reset", grant, LEDR, timeout, finish, 2'b01, 6'h3F, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", grant, LEDR, timeout, finish, 2'b00, 6'h00, 1'b0, 1'b0);
    step();
    reset = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("restart_grant", grant, LEDR, timeout, finish, 2'b01, 6'h00, 1'b0, 1'b0);
    step();
    check("restart_led", grant, LEDR, timeout, finish, 2'b01, 6'h3F, 1'b0, 1'b0);
    rel = 2'b01; req = 2'b00;
    step();
    rel = 2'b00;
    check("restart_end", grant, LEDR, timeout, finish, 2'b00, 6'h3F, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
